// File: rtl/button_input_pkg.sv
// Shared constants for the player input path: debounce timing and counter sizing
// sit beside the movement step used by the player logic.
package button_input_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int DEBOUNCE_CNT_W          = 20;
  localparam int PLAYER_STEP             = 2;

  typedef logic [DEBOUNCE_CNT_W-1:0] debounce_cnt_t;

endpackage

// File: rtl/debounce_channel.sv
// One push-button channel: two-flop synchronizer, saturating mismatch counter
// and the accepted (stable) level.
module debounce_channel
  import button_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  // The load happens on the mismatch edge that would take the count to DEBOUNCE_CYCLES.
  localparam debounce_cnt_t LOAD_AT = debounce_cnt_t'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  debounce_cnt_t cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == LOAD_AT) begin
      level <= sync2;
      cnt   <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + debounce_cnt_t'(1);
    end
  end

endmodule

// File: rtl/button_input.sv
// Player button front end: three debounced channels, left/right as levels and
// fire turned into a single request held until the next frame tick takes it.
module button_input
  import button_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic frame,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_fire,
  output logic left,
  output logic right,
  output logic fire_req
);

  logic fire_level;
  logic fire_prev;
  logic fire_press;

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_left),
    .level (left)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_right),
    .level (right)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_fire (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_fire),
    .level (fire_level)
  );

  assign fire_press = fire_level & ~fire_prev;

  // fire_req/frame handshake: fire_req is the valid, frame is the ready. A
  // request is consumed on any edge with frame=1 and fire_req=1, unless a new
  // press lands on that same edge, in which case the request stays up.
  always_ff @(posedge clk) begin
    if (rst) begin
      fire_prev <= 1'b0;
      fire_req  <= 1'b0;
    end else begin
      fire_prev <= fire_level;
      if (fire_press) begin
        fire_req <= 1'b1;
      end else if (frame && fire_req) begin
        fire_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_input.sv
// Bench for button_input with a short debounce window: an edge-indexed
// behavioural model checked every cycle, plus directed scenario checks.
module tb_button_input;

  localparam int D    = 4;
  localparam int MAXE = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame = 1'b0;
  logic btn_left = 1'b0;
  logic btn_right = 1'b0;
  logic btn_fire = 1'b0;
  logic left;
  logic right;
  logic fire_req;

  int tests = 0;
  int fails = 0;

  button_input #(.DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .frame     (frame),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_fire  (btn_fire),
    .left      (left),
    .right     (right),
    .fire_req  (fire_req)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: a level is accepted once the raw value seen two edges
  // earlier has disagreed with it for D edges in a row since the last change
  int   cyc = 0;
  logic raw_hist [3][0:MAXE-1];
  logic rst_hist [0:MAXE-1];
  logic m_level [3] = '{1'b0, 1'b0, 1'b0};
  int   m_flip [3] = '{0, 0, 0};
  logic m_req = 1'b0;
  logic m_press = 1'b0;
  logic model_valid = 1'b0;
  logic prev_fire;

  function automatic logic delayed(input int c, input int n);
    if (n < 2) return 1'b0;
    if (rst_hist[n-1] || rst_hist[n-2]) return 1'b0;
    return raw_hist[c][n-2];
  endfunction

  function automatic logic window_differs(input int c, input int n);
    for (int k = n - D + 1; k <= n; k++) begin
      if (delayed(c, k) == m_level[c]) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (cyc < MAXE) begin
      rst_hist[cyc]    = rst;
      raw_hist[0][cyc] = btn_left;
      raw_hist[1][cyc] = btn_right;
      raw_hist[2][cyc] = btn_fire;
      if (rst) m_req = 1'b0;
      else if (m_press) m_req = 1'b1;
      else if (frame && m_req) m_req = 1'b0;
      prev_fire = m_level[2];
      for (int c = 0; c < 3; c++) begin
        if (rst) begin
          m_level[c] = 1'b0;
          m_flip[c]  = cyc;
        end else if ((cyc - m_flip[c]) >= D && window_differs(c, cyc)) begin
          m_level[c] = ~m_level[c];
          m_flip[c]  = cyc;
        end
      end
      m_press = !rst && m_level[2] && !prev_fire;
      model_valid = 1'b1;
    end
    cyc++;
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (model_valid) begin
      check("model_left", left, m_level[0]);
      check("model_right", right, m_level[1]);
      check("model_fire_req", fire_req, m_req);
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int rises;
    logic prev_req;

    step(3);
    check("reset_left", left, 0);
    check("reset_right", right, 0);
    check("reset_fire_req", fire_req, 0);
    rst = 1'b0;
    step(2);

    // clean left press: accepted D+2 edges later
    btn_left = 1'b1;
    step(5);
    check("left_before_latency", left, 0);
    step(1);
    check("left_at_latency", left, 1);
    check("left_scn_right", right, 0);
    check("left_scn_fire", fire_req, 0);
    btn_left = 1'b0;
    step(5);
    check("left_release_early", left, 1);
    step(1);
    check("left_release", left, 0);
    step(4);

    // bouncing right: 3 high, 2 low, never long enough
    for (int i = 0; i < 40; i++) begin
      btn_right = ((i % 5) < 3);
      step(1);
      check("bounce_right", right, 0);
    end
    btn_right = 1'b0;
    step(4);
    check("bounce_right_end", right, 0);

    // fire held 100 cycles with frame ticks at 30 and 60
    rises = 0;
    prev_req = fire_req;
    btn_fire = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      step(1);
      if (fire_req && !prev_req) rises++;
      prev_req = fire_req;
      if (c == 6)  check("fire_edge6", fire_req, 0);
      if (c == 7)  check("fire_edge7", fire_req, 1);
      if (c == 29) check("fire_edge29", fire_req, 1);
      if (c == 30) check("fire_edge30", fire_req, 0);
      frame = (c == 29 || c == 59);
    end
    check("fire_hold_rises", rises, 1);
    check("fire_hold_end", fire_req, 0);
    btn_fire = 1'b0;
    step(8);

    // new press coinciding with frame while a request is already pending
    btn_fire = 1'b1;
    step(7);
    check("coincide_first_req", fire_req, 1);
    btn_fire = 1'b0;
    step(10);
    check("coincide_still_pending", fire_req, 1);
    btn_fire = 1'b1;
    step(6);
    frame = 1'b1;
    step(1);
    check("coincide_press_wins", fire_req, 1);
    frame = 1'b0;
    step(3);
    check("coincide_no_clear", fire_req, 1);
    frame = 1'b1;
    step(1);
    check("coincide_next_frame", fire_req, 0);
    frame = 1'b0;
    btn_fire = 1'b0;
    step(8);
    check("coincide_no_queue", fire_req, 0);

    // reset mid-count with left and fire held through reset
    btn_left = 1'b1;
    btn_fire = 1'b1;
    step(4);
    rst = 1'b1;
    step(1);
    check("midrst_left", left, 0);
    check("midrst_fire_req", fire_req, 0);
    step(1);
    rst = 1'b0;
    step(5);
    check("postrst_left_early", left, 0);
    step(1);
    check("postrst_left", left, 1);
    step(1);
    check("postrst_fire_req", fire_req, 1);
    btn_left = 1'b0;
    btn_fire = 1'b0;
    frame = 1'b1;
    step(1);
    frame = 1'b0;
    check("postrst_fire_cleared", fire_req, 0);
    step(8);

    // both directions held together
    btn_left = 1'b1;
    btn_right = 1'b1;
    step(5);
    check("both_left_early", left, 0);
    check("both_right_early", right, 0);
    step(1);
    check("both_left", left, 1);
    check("both_right", right, 1);
    btn_left = 1'b0;
    btn_right = 1'b0;
    step(8);
    check("both_released_left", left, 0);
    check("both_released_right", right, 0);

    @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
